// File: rtl/periph_port_arbiter_pkg.sv
// Shared types for the peripheral port arbiter: FSM state encodings,
// the packet-phase type used by the packet tracker, and an index helper.
`timescale 1ns/1ps
package HermesPkg;

   typedef enum logic [1:0] {U_IDLE, U_HEADER, U_SIZE, U_PAYLOAD} up_state_e;
   typedef enum logic [1:0] {D_IDLE, D_SIZE, D_PAYLOAD} dn_state_e;
   typedef enum logic [1:0] {PH_HEADER, PH_SIZE, PH_PAYLOAD} pkt_phase_e;

   localparam int ADDR_W = 16;

   // (base + off) modulo n, for base < n and off <= n
   function automatic int wrap_idx(input int base, input int off, input int n);
      int s;
      s = base + off;
      return (s >= n) ? s - n : s;
   endfunction

endpackage

// File: rtl/periph_port_arbiter_tracker.sv
// Follows one packet stream (header, size S, S payload flits) and flags the
// transfer that completes the packet.
`timescale 1ns/1ps
module periph_pkt_tracker
   import HermesPkg::*;
#(
   parameter int FLIT_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 xfer,
   input  logic [FLIT_SIZE-1:0] flit,
   output pkt_phase_e           phase,
   output logic                 last
);

   logic [FLIT_SIZE-1:0] count;

   // A zero-size packet ends on its size flit.
   always_comb begin
      last = xfer && (((phase == PH_SIZE) && (flit == '0)) ||
                      ((phase == PH_PAYLOAD) && (count == FLIT_SIZE'(1))));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase <= PH_HEADER;
         count <= '0;
      end else if (xfer) begin
         case (phase)
            PH_HEADER: phase <= PH_SIZE;
            PH_SIZE: begin
               count <= flit;
               phase <= (flit == '0) ? PH_HEADER : PH_PAYLOAD;
            end
            PH_PAYLOAD: begin
               count <= count - FLIT_SIZE'(1);
               if (last) phase <= PH_HEADER;
            end
            default: phase <= PH_HEADER;
         endcase
      end
   end

endmodule

// File: rtl/periph_port_arbiter.sv
// Shares one router boundary port among N_REQ peripherals: round-robin
// packet arbitration on the uplink, address-based routing on the downlink.
`timescale 1ns/1ps
module periph_port_arbiter
   import HermesPkg::*;
#(
   parameter int                      N_REQ     = 2,
   parameter int                      FLIT_SIZE = 32,
   parameter logic [N_REQ-1:0][15:0]  REQ_ADDR  = {16'h0100, 16'h0000}
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            release_i,
   input  logic [N_REQ-1:0]                src_rx_i,
   output logic [N_REQ-1:0]                src_credit_o,
   input  logic [N_REQ-1:0][FLIT_SIZE-1:0] src_data_i,
   output logic                            noc_tx_o,
   input  logic                            noc_credit_i,
   output logic [FLIT_SIZE-1:0]            noc_data_o,
   input  logic                            noc_rx_i,
   output logic                            noc_credit_o,
   input  logic [FLIT_SIZE-1:0]            noc_data_i,
   output logic [N_REQ-1:0]                dst_tx_o,
   input  logic [N_REQ-1:0]                dst_credit_i,
   output logic [N_REQ-1:0][FLIT_SIZE-1:0] dst_data_o,
   output logic [N_REQ-1:0]                grant_o,
   output up_state_e                       up_state_o,
   output dn_state_e                       dn_state_o
);

   localparam int IW = (N_REQ > 2) ? 2 : 1;

   up_state_e   up_state;
   dn_state_e   dn_state;
   pkt_phase_e  up_phase, dn_phase;
   logic        run, up_xfer, dn_xfer, up_last, dn_last;
   logic        pick_ok, match_ok, dhit, route_ok;
   logic [IW-1:0] rr_ptr, gidx, pick, cand, match_idx, dsel, route_idx;

   assign up_state_o = up_state;
   assign dn_state_o = dn_state;
   assign up_xfer    = noc_tx_o & noc_credit_i;
   assign dn_xfer    = noc_rx_i & noc_credit_o;

   always_comb begin
      pick = '0;
      pick_ok = 1'b0;
      cand = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IW'(wrap_idx(int'(rr_ptr), k, N_REQ));
         if (!pick_ok && src_rx_i[cand]) begin
            pick = cand;
            pick_ok = 1'b1;
         end
      end
   end

   // Descending scan so the lowest matching index wins.
   always_comb begin
      match_idx = '0;
      match_ok = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (REQ_ADDR[i] == noc_data_i[ADDR_W-1:0]) begin
            match_idx = IW'(i);
            match_ok = 1'b1;
         end
      end
   end

   always_comb begin
      src_credit_o = '0;
      noc_tx_o = 1'b0;
      noc_data_o = '0;
      if (up_state != U_IDLE) begin
         noc_tx_o = src_rx_i[gidx];
         noc_data_o = src_data_i[gidx];
         src_credit_o[gidx] = noc_credit_i;
      end
      route_ok = (dn_state == D_IDLE) ? match_ok : dhit;
      route_idx = (dn_state == D_IDLE) ? match_idx : dsel;
      dst_tx_o = '0;
      dst_data_o = '0;
      noc_credit_o = 1'b0;
      // run stays low for one cycle after reset so nothing moves right away.
      if (run) begin
         if (route_ok) begin
            dst_tx_o[route_idx] = noc_rx_i;
            dst_data_o[route_idx] = noc_data_i;
            noc_credit_o = dst_credit_i[route_idx];
         end else begin
            noc_credit_o = 1'b1;
         end
      end
   end

   periph_pkt_tracker #(.FLIT_SIZE(FLIT_SIZE)) u_up_trk (
      .clk(clk_i), .rst_n(rst_ni), .xfer(up_xfer), .flit(noc_data_o),
      .phase(up_phase), .last(up_last)
   );

   periph_pkt_tracker #(.FLIT_SIZE(FLIT_SIZE)) u_dn_trk (
      .clk(clk_i), .rst_n(rst_ni), .xfer(dn_xfer), .flit(noc_data_i),
      .phase(dn_phase), .last(dn_last)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         up_state <= U_IDLE;
         grant_o <= '0;
         gidx <= '0;
         rr_ptr <= '0;
      end else if (up_state == U_IDLE) begin
         if (release_i && pick_ok) begin
            up_state <= U_HEADER;
            gidx <= pick;
            grant_o <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
         end
      end else if (up_xfer) begin
         if (up_last) begin
            up_state <= U_IDLE;
            grant_o <= '0;
            rr_ptr <= IW'(wrap_idx(int'(gidx), 1, N_REQ));
         end else if (up_phase == PH_HEADER) begin
            up_state <= U_SIZE;
         end else begin
            up_state <= U_PAYLOAD;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         dn_state <= D_IDLE;
         dsel <= '0;
         dhit <= 1'b0;
         run <= 1'b0;
      end else begin
         run <= 1'b1;
         if (dn_xfer) begin
            if (dn_last) begin
               dn_state <= D_IDLE;
            end else if (dn_phase == PH_HEADER) begin
               dn_state <= D_SIZE;
               dsel <= match_idx;
               dhit <= match_ok;
            end else begin
               dn_state <= D_PAYLOAD;
            end
         end
      end
   end

endmodule

// File: tb/tb_periph_port_arbiter.sv
// Directed bench for periph_port_arbiter with two requesters and 32-bit flits.
`timescale 1ns/1ps
module tb_periph_port_arbiter;
   import HermesPkg::*;

   localparam int N = 2;
   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_ni, release_i, noc_tx_o, noc_credit_i, noc_rx_i, noc_credit_o;
   logic [N-1:0]      src_rx_i, src_credit_o, dst_tx_o, dst_credit_i, grant_o;
   logic [N-1:0][W-1:0] src_data_i, dst_data_o;
   logic [W-1:0]      noc_data_o, noc_data_i;
   up_state_e         up_state_o;
   dn_state_e         dn_state_o;

   periph_port_arbiter #(.N_REQ(N), .FLIT_SIZE(W)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .release_i(release_i),
      .src_rx_i(src_rx_i), .src_credit_o(src_credit_o), .src_data_i(src_data_i),
      .noc_tx_o(noc_tx_o), .noc_credit_i(noc_credit_i), .noc_data_o(noc_data_o),
      .noc_rx_i(noc_rx_i), .noc_credit_o(noc_credit_o), .noc_data_i(noc_data_i),
      .dst_tx_o(dst_tx_o), .dst_credit_i(dst_credit_i), .dst_data_o(dst_data_o),
      .grant_o(grant_o), .up_state_o(up_state_o), .dn_state_o(dn_state_o)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int drv_timeout = 0;
   int sink_cnt = 0;
   logic abort_up = 1'b0;

   logic [W-1:0] up_obs_q[$];
   logic [N-1:0] up_gnt_q[$];
   int           up_cyc_q[$];
   logic [W-1:0] dn_obs_q[$];
   int           dn_idx_q[$];
   logic [W-1:0] pkt_buf [N][16];
   logic [W-1:0] dn_buf [16];

   // Records, at each falling edge, the transfers the next rising edge performs.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_ni === 1'b1) begin
            if (noc_tx_o && noc_credit_i) begin
               up_obs_q.push_back(noc_data_o);
               up_gnt_q.push_back(grant_o);
               up_cyc_q.push_back(cyc);
            end
            for (int i = 0; i < N; i++) begin
               if (dst_tx_o[i] && dst_credit_i[i]) begin
                  dn_obs_q.push_back(dst_data_o[i]);
                  dn_idx_q.push_back(i);
               end
            end
            if (noc_rx_i && noc_credit_o && dst_tx_o == '0) sink_cnt++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      up_obs_q.delete();
      up_gnt_q.delete();
      up_cyc_q.delete();
      dn_obs_q.delete();
      dn_idx_q.delete();
   endtask

   task automatic drive_up(input int r, input int off, input int n);
      int k = 0;
      int waited = 0;
      while (k < n && waited < 60 && !abort_up) begin
         src_rx_i[r] = 1'b1;
         src_data_i[r] = pkt_buf[r][off+k];
         @(negedge clk);
         if (src_credit_o[r]) k++;
         @(posedge clk);
         #1;
         waited++;
      end
      src_rx_i[r] = 1'b0;
      src_data_i[r] = '0;
      if (k < n && !abort_up) drv_timeout++;
   endtask

   task automatic drive_dn(input int off, input int n);
      int k = 0;
      int waited = 0;
      while (k < n && waited < 60) begin
         noc_rx_i = 1'b1;
         noc_data_i = dn_buf[off+k];
         @(negedge clk);
         if (noc_credit_o) k++;
         @(posedge clk);
         #1;
         waited++;
      end
      noc_rx_i = 1'b0;
      noc_data_i = '0;
      if (k < n) drv_timeout++;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      release_i = 1'b1;
      src_rx_i = '1;
      src_data_i = {32'h1234_5678, 32'h9abc_def0};
      noc_rx_i = 1'b1;
      noc_data_i = 32'h0000_0000;
      dst_credit_i = '1;
      noc_credit_i = 1'b1;
      repeat (3) tick();
      checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
      checks++; if (src_credit_o !== 2'b00) begin errors++; $display("FAIL reset_src_credit: got %b expected 00", src_credit_o); end
      checks++; if (noc_tx_o !== 1'b0) begin errors++; $display("FAIL reset_noc_tx: got %b expected 0", noc_tx_o); end
      checks++; if (noc_data_o !== 32'h0) begin errors++; $display("FAIL reset_noc_data: got %h expected 0", noc_data_o); end
      checks++; if (noc_credit_o !== 1'b0) begin errors++; $display("FAIL reset_noc_credit: got %b expected 0", noc_credit_o); end
      checks++; if (dst_tx_o !== 2'b00) begin errors++; $display("FAIL reset_dst_tx: got %b expected 00", dst_tx_o); end
      checks++; if (dst_data_o !== 64'h0) begin errors++; $display("FAIL reset_dst_data: got %h expected 0", dst_data_o); end
      release_i = 1'b0;
      src_rx_i = '0;
      src_data_i = '0;
      noc_rx_i = 1'b0;
      rst_ni = 1'b1;
      tick();
      checks++; if (up_state_o !== U_IDLE || dn_state_o !== D_IDLE) begin errors++; $display("FAIL reset_states: got %0d/%0d expected 0/0", up_state_o, dn_state_o); end
   endtask

   task automatic test_single_packet();
      int c0;
      logic [W-1:0] exp_q[$];
      exp_q = '{32'h0000_0101, 32'd3, 32'ha000_0001, 32'ha000_0002, 32'ha000_0003};
      for (int i = 0; i < 5; i++) pkt_buf[0][i] = exp_q[i];
      release_i = 1'b1;
      noc_credit_i = 1'b1;
      clear_obs();
      c0 = cyc;
      drive_up(0, 0, 5);
      checks++; if (up_obs_q.size() !== 5) begin errors++; $display("FAIL single_count: got %0d expected 5", up_obs_q.size()); end
      if (up_obs_q.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            checks++; if (up_obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_flit%0d: got %h expected %h", i, up_obs_q[i], exp_q[i]); end
            checks++; if (up_gnt_q[i] !== 2'b01) begin errors++; $display("FAIL single_grant%0d: got %b expected 01", i, up_gnt_q[i]); end
            checks++; if (up_cyc_q[i] !== c0 + 2 + i) begin errors++; $display("FAIL single_cycle%0d: got %0d expected %0d", i, up_cyc_q[i], c0 + 2 + i); end
         end
      end
      checks++; if (grant_o !== 2'b00 || noc_tx_o !== 1'b0) begin errors++; $display("FAIL single_after: got grant=%b tx=%b expected 00/0", grant_o, noc_tx_o); end
   endtask

   task automatic test_round_robin();
      logic [W-1:0] exp_q[$];
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
      release_i = 1'b1;
      pkt_buf[0][0] = 32'h0000_0100; pkt_buf[0][1] = 32'd1; pkt_buf[0][2] = 32'hb0;
      pkt_buf[1][0] = 32'h0000_0000; pkt_buf[1][1] = 32'd2; pkt_buf[1][2] = 32'hc0; pkt_buf[1][3] = 32'hc1;
      pkt_buf[0][10] = 32'h0000_0100; pkt_buf[0][11] = 32'd0;
      exp_q = '{32'h100, 32'd1, 32'hb0, 32'h0, 32'd2, 32'hc0, 32'hc1};
      clear_obs();
      fork
         drive_up(0, 0, 3);
         drive_up(1, 0, 4);
      join
      checks++; if (up_obs_q.size() !== 7) begin errors++; $display("FAIL rr1_count: got %0d expected 7", up_obs_q.size()); end
      if (up_obs_q.size() == 7) begin
         for (int i = 0; i < 7; i++) begin
            checks++; if (up_obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr1_flit%0d: got %h expected %h", i, up_obs_q[i], exp_q[i]); end
         end
         checks++; if (up_gnt_q[0] !== 2'b01 || up_gnt_q[3] !== 2'b10) begin errors++; $display("FAIL rr1_grants: got %b,%b expected 01,10", up_gnt_q[0], up_gnt_q[3]); end
         checks++; if (up_cyc_q[3] !== up_cyc_q[2] + 2) begin errors++; $display("FAIL rr1_bubble: got gap %0d expected 2", up_cyc_q[3] - up_cyc_q[2]); end
      end
      clear_obs();
      drive_up(0, 10, 2);
      checks++; if (up_obs_q.size() !== 2 || up_state_o !== U_IDLE) begin errors++; $display("FAIL size0_pkt: got count=%0d state=%0d expected 2/0", up_obs_q.size(), up_state_o); end
      clear_obs();
      fork
         drive_up(0, 0, 3);
         drive_up(1, 0, 4);
      join
      checks++; if (up_obs_q.size() !== 7) begin errors++; $display("FAIL rr2_count: got %0d expected 7", up_obs_q.size()); end
      if (up_obs_q.size() == 7) begin
         checks++; if (up_obs_q[0] !== 32'h0 || up_gnt_q[0] !== 2'b10) begin errors++; $display("FAIL rr2_first: got %h/%b expected 0/10", up_obs_q[0], up_gnt_q[0]); end
         checks++; if (up_obs_q[4] !== 32'h100 || up_gnt_q[4] !== 2'b01) begin errors++; $display("FAIL rr2_second: got %h/%b expected 100/01", up_obs_q[4], up_gnt_q[4]); end
      end
   endtask

   task automatic test_release_gate();
      pkt_buf[0][0] = 32'h0000_0101; pkt_buf[0][1] = 32'd4;
      for (int i = 0; i < 4; i++) pkt_buf[0][2+i] = 32'hd0 + i;
      release_i = 1'b0;
      clear_obs();
      fork
         drive_up(0, 0, 6);
         begin
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               checks++;
               if (noc_tx_o !== 1'b0 || src_credit_o !== 2'b00 || grant_o !== 2'b00) begin
                  errors++; $display("FAIL release_hold%0d: got tx=%b credit=%b grant=%b expected 0/00/00", c, noc_tx_o, src_credit_o, grant_o);
               end
            end
            @(posedge clk); #2;
            release_i = 1'b1;
            @(negedge clk);
            checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL release_early: got %b expected 00", grant_o); end
            @(negedge clk);
            checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL release_grant: got %b expected 01", grant_o); end
            repeat (3) @(posedge clk);
            #2;
            release_i = 1'b0;
         end
      join
      checks++; if (up_obs_q.size() !== 6) begin errors++; $display("FAIL release_complete: got %0d expected 6", up_obs_q.size()); end
      if (up_obs_q.size() == 6) begin
         checks++; if (up_obs_q[5] !== 32'hd3) begin errors++; $display("FAIL release_last: got %h expected d3", up_obs_q[5]); end
      end
   endtask

   task automatic test_downlink();
      dn_buf[0] = 32'habcd_0100; dn_buf[1] = 32'd2; dn_buf[2] = 32'he0; dn_buf[3] = 32'he1;
      pkt_buf[1][8] = 32'h0000_0100; pkt_buf[1][9] = 32'd1; pkt_buf[1][10] = 32'hf1;
      release_i = 1'b1;
      dst_credit_i = 2'b01;
      clear_obs();
      fork
         drive_dn(0, 4);
         drive_up(1, 8, 3);
         begin
            for (int c = 0; c < 4; c++) begin
               @(negedge clk);
               checks++;
               if (noc_credit_o !== 1'b0 || dst_tx_o !== 2'b10 || dst_data_o[0] !== 32'h0) begin
                  errors++; $display("FAIL dn_stall%0d: got credit=%b tx=%b d0=%h expected 0/10/0", c, noc_credit_o, dst_tx_o, dst_data_o[0]);
               end
            end
            @(posedge clk); #2;
            dst_credit_i = 2'b11;
         end
      join
      checks++; if (dn_obs_q.size() !== 4) begin errors++; $display("FAIL dn_count: got %0d expected 4", dn_obs_q.size()); end
      if (dn_obs_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (dn_obs_q[i] !== dn_buf[i] || dn_idx_q[i] !== 1) begin errors++; $display("FAIL dn_flit%0d: got %h@%0d expected %h@1", i, dn_obs_q[i], dn_idx_q[i], dn_buf[i]); end
         end
      end
      checks++; if (up_obs_q.size() !== 3) begin errors++; $display("FAIL concurrent_up: got %0d expected 3", up_obs_q.size()); end
   endtask

   task automatic test_sink();
      int s0;
      dn_buf[4] = 32'h0000_0707; dn_buf[5] = 32'd0;
      dst_credit_i = 2'b00;
      s0 = sink_cnt;
      clear_obs();
      fork
         drive_dn(4, 2);
         begin
            @(negedge clk);
            checks++; if (noc_credit_o !== 1'b1 || dst_tx_o !== 2'b00) begin errors++; $display("FAIL sink_hdr: got credit=%b tx=%b expected 1/00", noc_credit_o, dst_tx_o); end
         end
      join
      checks++; if (sink_cnt - s0 !== 2) begin errors++; $display("FAIL sink_count: got %0d expected 2", sink_cnt - s0); end
      checks++; if (dn_obs_q.size() !== 0 || dn_state_o !== D_IDLE) begin errors++; $display("FAIL sink_nodst: got %0d/%0d expected 0/0", dn_obs_q.size(), dn_state_o); end
      dst_credit_i = 2'b11;
   endtask

   task automatic test_reset_mid();
      release_i = 1'b1;
      dst_credit_i = 2'b11;
      pkt_buf[0][10] = 32'h0000_0100; pkt_buf[0][11] = 32'd0;
      pkt_buf[1][0] = 32'h0000_0000; pkt_buf[1][1] = 32'd5;
      for (int i = 0; i < 5; i++) pkt_buf[1][2+i] = 32'h50 + i;
      drive_up(0, 10, 2);
      clear_obs();
      abort_up = 1'b0;
      fork
         drive_up(1, 0, 7);
         begin
            int w = 0;
            while (up_obs_q.size() < 4 && w < 40) begin
               @(posedge clk);
               w++;
            end
            checks++; if (w >= 40) begin errors++; $display("FAIL rstmid_wait: got %0d flits expected 4", up_obs_q.size()); end
            #2;
            rst_ni = 1'b0;
            abort_up = 1'b1;
            @(posedge clk);
            #2;
            rst_ni = 1'b1;
         end
      join
      checks++; if (up_obs_q.size() !== 4) begin errors++; $display("FAIL rstmid_count: got %0d expected 4", up_obs_q.size()); end
      checks++; if (grant_o !== 2'b00 || noc_tx_o !== 1'b0 || src_credit_o !== 2'b00 || noc_data_o !== 32'h0) begin
         errors++; $display("FAIL rstmid_outputs: got grant=%b tx=%b credit=%b data=%h expected zero", grant_o, noc_tx_o, src_credit_o, noc_data_o);
      end
      checks++; if (up_state_o !== U_IDLE) begin errors++; $display("FAIL rstmid_state: got %0d expected 0", up_state_o); end
      noc_rx_i = 1'b1;
      noc_data_i = 32'h0;
      #1;
      checks++; if (noc_credit_o !== 1'b0 || dst_tx_o !== 2'b00) begin errors++; $display("FAIL rstmid_quiet: got credit=%b tx=%b expected 0/00", noc_credit_o, dst_tx_o); end
      @(posedge clk);
      #1;
      checks++; if (noc_credit_o !== 1'b1 || dst_tx_o !== 2'b01) begin errors++; $display("FAIL rstmid_wake: got credit=%b tx=%b expected 1/01", noc_credit_o, dst_tx_o); end
      noc_rx_i = 1'b0;
      abort_up = 1'b0;
      pkt_buf[0][0] = 32'h0000_0100; pkt_buf[0][1] = 32'd1; pkt_buf[0][2] = 32'h11;
      pkt_buf[1][0] = 32'h0000_0000; pkt_buf[1][1] = 32'd1; pkt_buf[1][2] = 32'h22;
      clear_obs();
      fork
         drive_up(0, 0, 3);
         drive_up(1, 0, 3);
      join
      checks++; if (up_obs_q.size() !== 6) begin errors++; $display("FAIL rstmid_next_count: got %0d expected 6", up_obs_q.size()); end
      if (up_obs_q.size() == 6) begin
         checks++; if (up_obs_q[0] !== 32'h100 || up_gnt_q[0] !== 2'b01) begin errors++; $display("FAIL rstmid_next_first: got %h/%b expected 100/01", up_obs_q[0], up_gnt_q[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_round_robin();
      test_release_gate();
      test_downlink();
      test_sink();
      test_reset_mid();
      checks++; if (drv_timeout !== 0) begin errors++; $display("FAIL driver_timeout: got %0d expected 0", drv_timeout); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/periph_port_arbiter.md
PERIPH_PORT_ARBITER -- requirements
Module: periph_port_arbiter

Interface
REQ-001 Parameter N_REQ, default 2: number of peripheral requesters sharing one router boundary port (legal 2..4).
REQ-002 Parameter FLIT_SIZE, default 32: flit width in bits.
REQ-003 Parameter REQ_ADDR, default {16'h0100, 16'h0000}: N_REQ x 16-bit peripheral addresses, index 0 in the LSBs.
REQ-004 clk_i  input  1  sole clock, all state rising-edge.
REQ-005 rst_ni  input  1  reset, synchronous, active-low.
REQ-006 release_i  input  1  PE permits new uplink packets into the port.
REQ-007 src_rx_i  input  N_REQ  per-requester uplink flit valid.
REQ-008 src_credit_o  output  N_REQ  per-requester uplink credit.
REQ-009 src_data_i  input  N_REQ x FLIT_SIZE  per-requester uplink flit.
REQ-010 noc_tx_o  output  1 / noc_credit_i  input  1 / noc_data_o  output  FLIT_SIZE  uplink to router port.
REQ-011 noc_rx_i  input  1 / noc_credit_o  output  1 / noc_data_i  input  FLIT_SIZE  downlink from router port.
REQ-012 dst_tx_o  output  N_REQ / dst_credit_i  input  N_REQ / dst_data_o  output  N_REQ x FLIT_SIZE  per-requester downlink.
REQ-013 grant_o  output  N_REQ  one-hot current uplink owner, zero when idle.

Function
REQ-014 A flit transfers on any link exactly when valid and credit are both high at a rising edge.
REQ-015 Packet format is a header flit (target address in bits [15:0]), a size flit (payload count S, unsigned, full FLIT_SIZE), then S payload flits.
REQ-016 Uplink FSM states: U_IDLE, U_HEADER, U_SIZE, U_PAYLOAD.
REQ-017 In U_IDLE with release_i=1 and any src_rx_i high, the arbiter SHALL register a grant to the first requesting index at or after rr_ptr (wrapping modulo N_REQ) and enter U_HEADER.
REQ-018 In U_IDLE with release_i=0, no grant is issued; all src_credit_o=0 and noc_tx_o=0.
REQ-019 While granted: noc_tx_o=src_rx_i[g], noc_data_o=src_data_i[g], src_credit_o[g]=noc_credit_i, all other src_credit_o=0 (combinational, zero added latency).
REQ-020 Header transfer -> U_SIZE; size transfer loads counter with S -> U_PAYLOAD, or U_IDLE if S=0; each payload transfer decrements; transfer with counter=1 -> U_IDLE.
REQ-021 On return to U_IDLE, rr_ptr becomes (g+1) mod N_REQ and grant_o clears; a new grant earliest one cycle later (one bubble per packet).
REQ-022 release_i falling mid-packet SHALL NOT stall or truncate the current packet.
REQ-023 Downlink FSM states: D_IDLE, D_SIZE, D_PAYLOAD.
REQ-024 In D_IDLE, target index m = lowest i with REQ_ADDR[i]==noc_data_i[15:0]; header routed to dst m, noc_credit_o=dst_credit_i[m].
REQ-025 Header with no matching address SHALL be sunk: noc_credit_o=1, no dst_tx_o asserted, remainder of packet consumed likewise.
REQ-026 Select latched on header transfer; size/payload sequencing identical to REQ-020; non-selected dst_tx_o=0.
REQ-027 Uplink and downlink operate independently and concurrently.

Reset
REQ-028 While rst_ni=0 at an edge: both FSMs idle, counters 0, rr_ptr=0, grant_o=0; all credit and tx outputs 0; data outputs 0.
REQ-029 Reset mid-packet abandons the packet; no flit transfers in the cycle following reset release.

Structure
REQ-030 Uplink/downlink state enums and packet-phase typedef belong in HermesPkg.
REQ-031 Header/size/payload counting SHALL be a sub-module periph_pkt_tracker (inputs: transfer strobe, flit; outputs: phase, last), instantiated once per direction.

Verification
REQ-032 Req0 sends header 16'h0101, size 3, 3 payloads, credit always 1 -> noc_tx_o 1 cycle after src_rx_i, 5 consecutive flits, grant_o=01 then 00.
REQ-033 Req0 and Req1 assert same cycle from reset -> req0 packet first, then req1 after one bubble; repeat -> req1 granted first (rr).
REQ-034 release_i=0 with pending requests for 10 cycles -> no noc_tx_o, no credit; raise release_i -> grant next cycle; drop mid-payload -> packet completes.
REQ-035 Downlink header 16'h0100, size 2 -> delivered only on dst 1; dst_credit_i[1] low 4 cycles -> noc_credit_o low same cycles.
REQ-036 Downlink header 16'h0707, size 0 -> both flits sunk, no dst_tx_o.
REQ-037 Size 0 uplink packet and rst_ni pulse during payload -> FSM idle, outputs zero, next packet arbitrates from index 0.
